// File: rtl/bus_cycle_pkg.sv
// Shared types for the multiplexed bus cycle controller:
// FSM state encoding, cycle kinds and S1/S0 status codes.
package bus_cycle_pkg;

    typedef enum logic [2:0] {
        T_IDLE,
        T1,
        T2,
        TW,
        T3
    } state_t;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        FETCH = 2'd2
    } cyc_kind_t;

    localparam logic [1:0] S1S0_IDLE  = 2'b00;
    localparam logic [1:0] S1S0_READ  = 2'b10;
    localparam logic [1:0] S1S0_WRITE = 2'b01;
    localparam logic [1:0] S1S0_FETCH = 2'b11;

    // The unused kind encoding is treated as a plain read.
    function automatic logic [1:0] kind_status(input cyc_kind_t k);
        logic [1:0] s;
        case (k)
            WRITE:   s = S1S0_WRITE;
            FETCH:   s = S1S0_FETCH;
            default: s = S1S0_READ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// Multiplexed address/data bus cycle controller (T1/T2/TW/T3).
// Ports: req_* request side, rsp_* completion side, bus pins ALE..READY.
module bus_cycle_ctrl
    import bus_cycle_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  cyc_kind_t                req_kind,
    input  logic                     req_io,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_timeout,
    output logic                     ALE,
    output logic                     S0,
    output logic                     S1,
    output logic                     IOMn,
    output logic                     RDn,
    output logic                     WRn,
    output logic [ADDR_W-DATA_W-1:0] A_HI,
    output logic [DATA_W-1:0]        AD_out,
    output logic                     AD_oe,
    input  logic [DATA_W-1:0]        AD_in,
    input  logic                     READY
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam bit TMO_EN = (MAX_WAIT > 0);

    state_t              r_state;
    state_t              w_next;
    cyc_kind_t           r_kind;
    logic                r_io;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_wcnt;
    logic                r_to;
    logic                r_rsp_valid;
    logic                r_rsp_timeout;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_accept;
    logic                w_is_wr;
    logic [CNT_W-1:0]    w_wcnt_inc;
    logic                w_tmo;

    assign w_accept   = (r_state == T_IDLE) && req_valid;
    assign w_is_wr    = (r_kind == WRITE);
    assign w_wcnt_inc = r_wcnt + 1'b1;
    // Timeout fires on the TW cycle whose increment reaches the limit,
    // so exactly MAX_WAIT wait states are inserted; READY still wins.
    assign w_tmo      = TMO_EN && !READY && (w_wcnt_inc == MAX_CNT);

    assign rsp_valid   = r_rsp_valid;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_rdata   = r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= T_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        ALE       = 1'b0;
        S1        = 1'b0;
        S0        = 1'b0;
        IOMn      = 1'b0;
        RDn       = 1'b1;
        WRn       = 1'b1;
        A_HI      = '0;
        AD_out    = '0;
        AD_oe     = 1'b0;

        // Status and upper address are held for the whole cycle.
        if (r_state != T_IDLE) begin
            {S1, S0} = kind_status(r_kind);
            IOMn     = r_io;
            A_HI     = r_addr[ADDR_W-1:DATA_W];
        end

        if (r_state inside {T2, TW, T3}) begin
            if (w_is_wr) begin
                WRn    = 1'b0;
                AD_out = r_wdata;
                AD_oe  = 1'b1;
            end else begin
                RDn    = 1'b0;
            end
        end

        unique case (r_state)
            T_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = T1;
                end
            end
            T1: begin
                ALE    = 1'b1;
                AD_out = r_addr[DATA_W-1:0];
                AD_oe  = 1'b1;
                w_next = T2;
            end
            T2: begin
                w_next = READY ? T3 : TW;
            end
            TW: begin
                w_next = (READY || w_tmo) ? T3 : TW;
            end
            T3: begin
                w_next = T_IDLE;
            end
            default: begin
                w_next = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kind        <= READ;
            r_io          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wcnt        <= '0;
            r_to          <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_kind  <= req_kind;
                r_io    <= req_io;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wcnt  <= '0;
                r_to    <= 1'b0;
            end
            if (r_state == TW) begin
                r_wcnt <= w_wcnt_inc;
                if (w_tmo) begin
                    r_to <= 1'b1;
                end
            end
            if (r_state == T3) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_timeout <= r_to;
                if (!w_is_wr) begin
                    r_rsp_rdata <= AD_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed, table-driven bench for bus_cycle_ctrl.
// Checks bus phases, wait states, timeout and mid-cycle reset.
module tb_bus_cycle_ctrl;
    import bus_cycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    cyc_kind_t   req_kind;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        ALE, S0, S1, IOMn, RDn, WRn, AD_oe, READY;
    logic [7:0]  A_HI;
    logic [7:0]  AD_out;
    logic [7:0]  AD_in;

    int checks = 0;
    int failures = 0;

    bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .ALE(ALE), .S0(S0), .S1(S1), .IOMn(IOMn),
        .RDn(RDn), .WRn(WRn), .A_HI(A_HI),
        .AD_out(AD_out), .AD_oe(AD_oe),
        .AD_in(AD_in), .READY(READY)
    );

    always #5 clk = ~clk;

    typedef struct {
        cyc_kind_t   kind;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  ad_in;
        int          nlow;
        logic [1:0]  exp_s;
        int          exp_lat;
        logic [7:0]  exp_rd;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input int id, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s actual=0x%0h required=0x%0h",
                     id, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk(200, "rd_wr_excl", {31'b0, (!RDn && !WRn)}, 0);
            chk(200, "ale_strobe", {31'b0, (ALE && (!RDn || !WRn))}, 0);
        end
    end

    task automatic chk_idle(input int id);
        chk(id, "idle_ale", ALE, 0);
        chk(id, "idle_rdn", RDn, 1);
        chk(id, "idle_wrn", WRn, 1);
        chk(id, "idle_oe", AD_oe, 0);
        chk(id, "idle_s", {S1, S0}, 0);
        chk(id, "idle_iomn", IOMn, 0);
        chk(id, "idle_ahi", A_HI, 0);
        chk(id, "idle_ad", AD_out, 0);
        chk(id, "idle_ready", req_ready, 1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int lat;
        int sn;
        lat = 0;
        sn = 0;
        @(negedge clk);
        chk(id, "req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_kind  = v.kind;
        req_io    = v.io;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        AD_in     = v.ad_in;
        READY     = 1'b1;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk(id, "t1_ale", ALE, 1);
                chk(id, "t1_ad", AD_out, v.addr[7:0]);
                chk(id, "t1_oe", AD_oe, 1);
                chk(id, "t1_ahi", A_HI, v.addr[15:8]);
                chk(id, "t1_iomn", IOMn, v.io);
                chk(id, "t1_s", {S1, S0}, v.exp_s);
                chk(id, "t1_busy", req_ready, 0);
                // Conflicting request while busy must be ignored.
                req_kind  = (v.kind == WRITE) ? READ : WRITE;
                req_io    = ~v.io;
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
            end else begin
                req_valid = 1'b0;
            end
            if (!RDn || !WRn) begin
                chk(id, "dp_s", {S1, S0}, v.exp_s);
                chk(id, "dp_iomn", IOMn, v.io);
                chk(id, "dp_ahi", A_HI, v.addr[15:8]);
                chk(id, "dp_ale", ALE, 0);
                if (v.kind == WRITE) begin
                    chk(id, "wr_wrn", WRn, 0);
                    chk(id, "wr_oe", AD_oe, 1);
                    chk(id, "wr_ad", AD_out, v.wdata);
                end else begin
                    chk(id, "rd_rdn", RDn, 0);
                    chk(id, "rd_oe", AD_oe, 0);
                end
                READY = (sn >= v.nlow);
                sn++;
            end
            if (rsp_valid) begin
                lat = c;
            end
        end
        chk(id, "latency", lat, v.exp_lat);
        chk(id, "rdata", rsp_rdata, v.exp_rd);
        chk(id, "timeout", rsp_timeout, v.exp_to);
        chk_idle(id);
        READY = 1'b1;
        @(negedge clk);
        chk(id, "pulse_end", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{READ,  1'b0, 16'h1234, 8'h00, 8'hA5,  0,
                    2'b10,  4, 8'hA5, 1'b0};
        vecs[1] = '{WRITE, 1'b1, 16'h0080, 8'h5A, 8'hFF,  0,
                    2'b01,  4, 8'hA5, 1'b0};
        vecs[2] = '{FETCH, 1'b0, 16'hBEEF, 8'h00, 8'h3C,  3,
                    2'b11,  7, 8'h3C, 1'b0};
        vecs[3] = '{READ,  1'b1, 16'hFF00, 8'h00, 8'h77,  7,
                    2'b10, 11, 8'h77, 1'b0};
        vecs[4] = '{READ,  1'b0, 16'h4321, 8'h00, 8'h96, 20,
                    2'b10, 11, 8'h96, 1'b1};
        vecs[5] = '{WRITE, 1'b0, 16'hA55A, 8'hC3, 8'h11,  1,
                    2'b01,  5, 8'h96, 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_kind  = READ;
        req_io    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        AD_in     = '0;
        READY     = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle(100);
        chk(100, "rst_valid", rsp_valid, 0);
        chk(100, "rst_tmo", rsp_timeout, 0);
        chk(100, "rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle(101);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a wait state aborts silently.
        @(negedge clk);
        req_valid = 1'b1;
        req_kind  = READ;
        req_io    = 1'b0;
        req_addr  = 16'h1357;
        AD_in     = 8'hE1;
        READY     = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk(102, "t1_ale", ALE, 1);
        @(negedge clk);
        chk(102, "t2_rdn", RDn, 0);
        @(negedge clk);
        chk(102, "tw_rdn", RDn, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(102);
        chk(102, "abort_valid", rsp_valid, 0);
        chk(102, "abort_rdata", rsp_rdata, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(102, "no_rsp", rsp_valid, 0);
        end
        READY = 1'b1;
        run_vec(6, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
